// File: rtl/insertion_sort_pack.sv
// insertion_sort_pack: sorts blocks of NUM_ELEMS unsigned words with an
// insertion-sort register array, then packs each sorted block into one wide
// AXI-Stream beat (element i, the i-th smallest, at [i*DATA_WIDTH +: DATA_WIDTH]).
// Fill and drain of the sort array do not overlap; the pack stage can accept a
// new beat in the same cycle its output is taken.
module insertion_sort_pack #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     src_tvalid,
    output logic                                     src_tready,
    input  logic [DATA_WIDTH-1:0]                    src_tdata,
    input  logic                                     src_tlast,
    output logic                                     dest_tvalid,
    input  logic                                     dest_tready,
    output logic [(2**ADDR_WIDTH)*DATA_WIDTH-1:0]    dest_tdata,
    output logic                                     dest_tlast
);

    localparam int NUM_ELEMS = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_ELEMS - 1);

    // Block length is fixed, so the upstream last flag carries no information.
    logic unused_tlast;
    assign unused_tlast = src_tlast;

    // ------------------------------------------------------------------
    // Sort stage
    // ------------------------------------------------------------------
    typedef enum logic {
        S_FILL  = 1'b0,
        S_DRAIN = 1'b1
    } sort_state_t;

    sort_state_t           state;
    logic [DATA_WIDTH-1:0] slots     [NUM_ELEMS];
    logic [DATA_WIDTH-1:0] slots_ins [NUM_ELEMS];
    logic [NUM_ELEMS-1:0]  gt;
    logic [ADDR_WIDTH-1:0] count;

    // Internal stream between the sort and pack stages.
    logic                  sort_tvalid;
    logic                  sort_tready;
    logic [DATA_WIDTH-1:0] sort_tdata;
    logic                  sort_tlast;

    // Parallel compare of the new element against every occupied slot, and
    // the array contents after inserting it (larger values shift up one slot).
    always_comb begin
        // NOTE: every variable driven here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        gt = '0;
        for (int i = 0; i < NUM_ELEMS; i++) begin
            slots_ins[i] = slots[i];
        end
        for (int i = 0; i < NUM_ELEMS; i++) begin
            gt[i] = (i < int'(count)) && (slots[i] > src_tdata);
        end
        // Occupied slots are sorted, so gt is a contiguous run ending at
        // count-1; the new element lands just below that run (after equals).
        if (gt[0] || (count == '0)) begin
            slots_ins[0] = src_tdata;
        end
        for (int i = 1; i < NUM_ELEMS; i++) begin
            if (gt[i-1]) begin
                slots_ins[i] = slots[i-1];
            end else if (gt[i] || (int'(count) == i)) begin
                slots_ins[i] = src_tdata;
            end
        end
    end

    // Sort FSM: fill the array one element per handshake, then drain it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_FILL;
            count      <= '0;
            src_tready <= 1'b0;
            // NOTE: the slot array is reset too, so its contents are defined
            // from reset rather than left at power-up values.
            for (int i = 0; i < NUM_ELEMS; i++) begin
                slots[i] <= '0;
            end
        end else begin
            case (state)
                S_FILL: begin
                    src_tready <= 1'b1;
                    if (src_tvalid && src_tready) begin
                        slots <= slots_ins;
                        if (count == LAST_IDX) begin
                            state      <= S_DRAIN;
                            count      <= '0;
                            src_tready <= 1'b0;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    src_tready <= 1'b0;
                    if (sort_tready) begin
                        if (count == LAST_IDX) begin
                            state      <= S_FILL;
                            count      <= '0;
                            src_tready <= 1'b1;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                end
                default: begin
                    state      <= S_FILL;
                    count      <= '0;
                    src_tready <= 1'b0;
                end
            endcase
        end
    end

    // During drain, count walks slot 0 upward onto the internal stream.
    always_comb begin
        sort_tvalid = (state == S_DRAIN);
        sort_tdata  = slots[count];
        sort_tlast  = (count == LAST_IDX);
    end

    // ------------------------------------------------------------------
    // Pack stage
    // ------------------------------------------------------------------
    logic [NUM_ELEMS-1:0][DATA_WIDTH-1:0] pack_reg;
    logic [NUM_ELEMS-1:0][DATA_WIDTH-1:0] pack_next;
    logic [ADDR_WIDTH-1:0]                beat_cnt;
    logic                                 last_acc;

    assign sort_tready = !dest_tvalid || dest_tready;

    // Packing register with the current beat dropped into its slot.
    always_comb begin
        pack_next           = pack_reg;
        pack_next[beat_cnt] = sort_tdata;
    end

    // Collect NUM_ELEMS beats, then present them as one held output beat.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pack_reg    <= '0;
            beat_cnt    <= '0;
            last_acc    <= 1'b0;
            dest_tvalid <= 1'b0;
            dest_tdata  <= '0;
            dest_tlast  <= 1'b0;
        end else begin
            if (dest_tvalid && dest_tready) begin
                dest_tvalid <= 1'b0;
            end
            if (sort_tvalid && sort_tready) begin
                pack_reg <= pack_next;
                if (beat_cnt == LAST_IDX) begin
                    dest_tdata  <= pack_next;
                    dest_tlast  <= last_acc || sort_tlast;
                    dest_tvalid <= 1'b1;
                    beat_cnt    <= '0;
                    last_acc    <= 1'b0;
                end else begin
                    beat_cnt <= beat_cnt + 1'b1;
                    last_acc <= last_acc || sort_tlast;
                end
            end
        end
    end

endmodule

// File: tb/tb_insertion_sort_pack.sv
// Scoreboard bench for insertion_sort_pack at default parameters (8-bit, 4 elements).
// Stimulus pushes each block's expected packed result; a monitor pops on every
// dest handshake and compares data, last flag and ascending order.
module tb_insertion_sort_pack;

    logic        clk;
    logic        rst;
    logic        src_tvalid;
    logic        src_tready;
    logic [7:0]  src_tdata;
    logic        src_tlast;
    logic        dest_tvalid;
    logic        dest_tready;
    logic [31:0] dest_tdata;
    logic        dest_tlast;

    int          n_vec;
    int          n_miscomp;
    int          n_beats;
    int          n_blocks;
    int          ready_mode;   // 0: hold low, 1: hold high, 2: random
    logic [31:0] exp_q[$];

    insertion_sort_pack #(.DATA_WIDTH(8), .ADDR_WIDTH(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .src_tvalid  (src_tvalid),
        .src_tready  (src_tready),
        .src_tdata   (src_tdata),
        .src_tlast   (src_tlast),
        .dest_tvalid (dest_tvalid),
        .dest_tready (dest_tready),
        .dest_tdata  (dest_tdata),
        .dest_tlast  (dest_tlast)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_vec++;
        if (actual !== expected) begin
            n_miscomp++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Reference result: plain bubble sort of the block, packed smallest first.
    function automatic logic [31:0] sorted_pack(input logic [3:0][7:0] e);
        logic [7:0] a [4];
        logic [7:0] t;
        for (int i = 0; i < 4; i++) a[i] = e[i];
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < 3 - p; i++) begin
                if (a[i] > a[i+1]) begin
                    t = a[i]; a[i] = a[i+1]; a[i+1] = t;
                end
            end
        end
        return {a[3], a[2], a[1], a[0]};
    endfunction

    // dest_tready driver, updated just after each rising edge.
    initial begin
        dest_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode == 2) dest_tready = 1'($urandom_range(0, 1));
            else                 dest_tready = (ready_mode == 1);
        end
    end

    // Monitor: sample at the falling edge; valid && ready here means a
    // handshake at the next rising edge.
    initial begin
        logic [31:0] exp_v;
        logic        asc;
        forever begin
            @(negedge clk);
            if (rst && dest_tvalid && dest_tready) begin
                n_beats++;
                asc = 1'b1;
                for (int i = 0; i < 3; i++) begin
                    if (dest_tdata[i*8 +: 8] > dest_tdata[(i+1)*8 +: 8]) asc = 1'b0;
                end
                check("dest_ascending", asc, 1);
                check("dest_tlast", dest_tlast, 1);
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_miscomp++;
                    $display("FAIL unexpected_beat: got %h, expected no beat", dest_tdata);
                end else begin
                    exp_v = exp_q.pop_front();
                    check("dest_tdata", dest_tdata, exp_v);
                end
            end
        end
    end

    // Drive n elements of e (e[0] first); caller is just after a rising edge.
    task automatic feed(input logic [3:0][7:0] e, input int n, input int gap_pct);
        logic hs;
        int   waited;
        for (int k = 0; k < n; k++) begin
            if (gap_pct > 0 && int'($urandom_range(0, 99)) < gap_pct) begin
                src_tvalid = 1'b0;
                repeat ($urandom_range(1, 2)) begin
                    @(posedge clk);
                    #1;
                end
            end
            src_tvalid = 1'b1;
            src_tdata  = e[k];
            src_tlast  = (k == n - 1);
            hs         = 1'b0;
            waited     = 0;
            while (!hs && waited < 200) begin
                @(negedge clk);
                hs = src_tready;
                @(posedge clk);
                #1;
                waited++;
            end
            check("src_handshake", hs, 1);
        end
        src_tvalid = 1'b0;
        src_tlast  = 1'b0;
    endtask

    task automatic feed_block(input logic [7:0] a, b, c, d, input logic [31:0] exp_v);
        exp_q.push_back(exp_v);
        n_blocks++;
        feed({d, c, b, a}, 4, 0);
    endtask

    // Wait (bounded) until every expected block has been seen.
    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0]      obs_ready;
        logic [5:0]      obs_valid;
        logic [31:0]     held;
        logic            stable;
        logic            src_seen;
        logic [3:0][7:0] e;
        int              waited;

        n_vec      = 0;
        n_miscomp  = 0;
        n_beats    = 0;
        n_blocks   = 0;
        ready_mode = 1;
        rst        = 1'b0;
        src_tvalid = 1'b0;
        src_tdata  = '0;
        src_tlast  = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_dest_tvalid", dest_tvalid, 0);
        check("rst_dest_tlast", dest_tlast, 0);
        check("rst_dest_tdata", dest_tdata, 0);
        check("rst_src_tready", src_tready, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("src_tready_after_rst", src_tready, 1);

        // Basic block plus latency profile after the 4th input edge
        feed_block(8'h30, 8'h10, 8'h40, 8'h20, 32'h40302010);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            obs_ready[k] = src_tready;
            obs_valid[k] = dest_tvalid;
        end
        check("src_tready_profile", obs_ready, 6'b110000);
        check("dest_tvalid_profile", obs_valid, 6'b010000);
        @(posedge clk);
        #1;
        wait_idle(100);

        // Duplicates, extremes, sorted and reversed input, back to back
        feed_block(8'hFF, 8'h00, 8'hFF, 8'h00, 32'hFFFF0000);
        feed_block(8'h05, 8'h05, 8'h05, 8'h05, 32'h05050505);
        feed_block(8'h01, 8'h02, 8'h03, 8'h04, 32'h04030201);
        feed_block(8'h04, 8'h03, 8'h02, 8'h01, 32'h04030201);
        wait_idle(200);

        // Backpressure: output held while a second block waits behind it
        ready_mode = 0;
        @(posedge clk);
        #1;
        feed_block(8'h11, 8'h33, 8'h22, 8'h44, 32'h44332211);
        waited = 0;
        while (!dest_tvalid && waited < 50) begin
            @(posedge clk);
            #1;
            waited++;
        end
        check("bp_dest_tvalid", dest_tvalid, 1);
        feed_block(8'h0A, 8'h0C, 8'h0B, 8'h0D, 32'h0D0C0B0A);
        @(negedge clk);
        held     = dest_tdata;
        stable   = 1'b1;
        src_seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (dest_tdata !== held || !dest_tvalid) stable = 1'b0;
            if (src_tready) src_seen = 1'b1;
        end
        check("bp_held_data", held, 32'h44332211);
        check("bp_stable", stable, 1);
        check("bp_src_tready_low", src_seen, 0);
        ready_mode = 1;
        wait_idle(100);
        @(negedge clk);
        check("bp_src_tready_back", src_tready, 1);
        @(posedge clk);
        #1;

        // Reset mid-fill discards the partial block
        feed({8'h00, 8'h00, 8'h55, 8'h66}, 2, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_dest_tvalid", dest_tvalid, 0);
        check("midrst_src_tready", src_tready, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        feed_block(8'h09, 8'h07, 8'h08, 8'h06, 32'h09080706);
        wait_idle(100);

        // Random blocks with input gaps and output backpressure
        ready_mode = 2;
        for (int b = 0; b < 300; b++) begin
            for (int k = 0; k < 4; k++) begin
                e[k] = (b % 2 == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 7));
            end
            exp_q.push_back(sorted_pack(e));
            n_blocks++;
            feed(e, 4, 30);
        end
        wait_idle(2000);
        ready_mode = 1;

        check("beat_count", n_beats, n_blocks);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscomp);
        $finish;
    end

endmodule
